core_dbg_ctrl: RTL
==================

Name: core_dbg_ctrl

Overview:
Synthesizable program-load / run / register-dump controller for the pipelined RISC-V core, wrapping Top.
- Streams a program into instruction memory through a valid/ready port.
- Releases the core from reset for a programmed number of cycles.
- Freezes the core and streams all architectural registers out through a second valid/ready port.
- Replaces hierarchical memory and register-file pokes with a parametrised, handshaked, self-timed sequence.

Parameters:
IMEM_DEPTH, 64, instruction memory words (power of two, ≥2); address width AW = clog2(IMEM_DEPTH)
XLEN, 32, instruction and register data width
NREGS, 32, registers dumped, indices 0..NREGS-1 (≤32)
CYC_W, 16, width of run-cycle count

Ports:
CLK  in  1  clock, rising edge
RST  in  1  synchronous reset, active-high
start  in  1  one-cycle pulse; begins a load/run/dump sequence
run_cycles  in  CYC_W  core run length; sampled when start is accepted
load_valid  in  1  program beat valid
load_ready  out  1  program beat accepted when valid&ready
load_data  in  XLEN  instruction word
load_last  in  1  marks final program beat
imem_we  out  1  instruction memory write enable
imem_waddr  out  AW  word address
imem_wdata  out  XLEN  write data
core_rst  out  1  holds core in reset (active-high)
core_stall  out  1  freezes core pipeline and register file writes
rf_raddr  out  5  register-file debug read address
rf_rdata  in  XLEN  register-file debug read data (combinational read)
dump_valid  out  1  dump beat valid
dump_ready  in  1  dump beat consumed when valid&ready
dump_idx  out  5  register index of current beat
dump_data  out  XLEN  register value of current beat
busy  out  1  high in LOAD/RUN/DUMP
done  out  1  high in DONE
ovf_err  out  1  sticky: program exceeded IMEM_DEPTH

Behaviour:
- Reset values: core_rst=1; all other outputs 0. State=IDLE; waddr counter, run counter and dump index are 0. RST asserted in any state returns to IDLE on the next edge, with no further imem writes or dump beats.
- States: IDLE, LOAD, RUN, DUMP, DONE. start is honoured only in IDLE and DONE and is ignored elsewhere.
- IDLE / DONE + start:
  - go to LOAD; clear waddr, ovf_err and done; latch run_cycles.
- LOAD:
  - load_ready=1; core_rst=1.
  - imem_we = load_valid&load_ready (same cycle); imem_waddr = counter; imem_wdata = load_data.
  - Each accepted beat increments the counter.
  - Accepted beat with load_last goes to RUN.
  - Beat accepted at address IMEM_DEPTH-1 without last: set ovf_err and go to RUN (program truncated). No wrap-around; load_ready=0 outside LOAD.
- RUN:
  - core_rst=0 and core_stall=0 for exactly the latched run_cycles cycles, counted down from entry.
  - Counter reaching 1 goes to DUMP on the next edge.
  - Latched value 0: LOAD goes directly to DUMP; core_rst never deasserts.
- DUMP:
  - core_stall=1 and core_rst=0, so the register file holds its state.
  - rf_raddr = dump_idx; dump_data = rf_rdata; dump_valid=1.
  - While valid&!ready, dump_idx and dump_data stay stable.
  - On valid&ready, dump_idx increments.
  - Beat NREGS-1 accepted goes to DONE.
- DONE:
  - done=1; core_stall=1; dump_valid=0; ovf_err holds.
- busy = state in {LOAD, RUN, DUMP}.
- LOAD/DUMP state changes are registered: first beat is accepted the cycle after entering the state.
- Counters use unsigned arithmetic with no overflow beyond the stated bounds.

Decomposition:
- Package core_dbg_pkg:
  - state enum (IDLE, LOAD, RUN, DUMP, DONE)
  - RF_AW=5
  - default IMEM_DEPTH, XLEN, CYC_W constants
- One natural sub-module, core_dbg_timer: loadable CYC_W down-counter with zero-detect, used for RUN. Everything else lives in core_dbg_ctrl.

Test Plan:
1. Basic sequence: start, run_cycles=20, 13 beats with last on beat 13 → 13 imem writes at addrs 0..12; core_rst low for exactly 20 cycles; 32 dump beats with idx 0..31; then done=1, busy=0.
2. Dump backpressure: regfile preset x[i]=i; dump_ready toggles 1,0,0,1… → dump_idx and dump_data stable while stalled; values 0..31 in order with no skip or duplicate.
3. Overflow: IMEM_DEPTH=8, 10 beats with no last → exactly 8 writes (addrs 0..7); ovf_err=1; load_ready=0 for beats 9–10; sequence proceeds to RUN.
4. Zero run: run_cycles=0 → no cycle with core_rst=0 before DUMP; dump starts 1 cycle after the last load beat.
5. Reset mid-run: RST high during RUN cycle 5 → next cycle IDLE with core_rst=1, busy=0, done=0, dump_valid=0.
6. Ignored/restart start: start pulse in RUN → no effect; start in DONE → LOAD with ovf_err and done cleared, waddr=0.

Source files
------------

// File: rtl/core_dbg_pkg.sv
// Shared types and defaults for the debug load/run/dump controller.
package core_dbg_pkg;

    localparam int RF_AW          = 5;
    localparam int DEF_IMEM_DEPTH = 64;
    localparam int DEF_XLEN       = 32;
    localparam int DEF_NREGS      = 32;
    localparam int DEF_CYC_W      = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DUMP,
        ST_DONE
    } state_e;

endpackage

// File: rtl/core_dbg_timer.sv
// Loadable down-counter that times the RUN window; saturates at zero.
module core_dbg_timer import core_dbg_pkg::*; #(
    parameter int CYC_W = DEF_CYC_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CYC_W-1:0] val_i,
    input  logic             dec_i,
    output logic             zero_o,
    output logic             one_o
);

    logic [CYC_W-1:0] cnt_q, cnt_d;

    // Next count: load wins over decrement, never go below zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = val_i;
        else if (dec_i && (cnt_q != '0))
            cnt_d = cnt_q - 1'b1;
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign zero_o = (cnt_q == '0);
    assign one_o  = (cnt_q == CYC_W'(1));

endmodule

// File: rtl/core_dbg_ctrl.sv
// Program-load / run / register-dump sequencer wrapped around the core.
module core_dbg_ctrl import core_dbg_pkg::*; #(
    parameter  int IMEM_DEPTH = DEF_IMEM_DEPTH,
    parameter  int XLEN       = DEF_XLEN,
    parameter  int NREGS      = DEF_NREGS,
    parameter  int CYC_W      = DEF_CYC_W,
    localparam int AW         = $clog2(IMEM_DEPTH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [CYC_W-1:0] run_cycles,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [XLEN-1:0]  load_data,
    input  logic             load_last,
    output logic             imem_we,
    output logic [AW-1:0]    imem_waddr,
    output logic [XLEN-1:0]  imem_wdata,
    output logic             core_rst,
    output logic             core_stall,
    output logic [RF_AW-1:0] rf_raddr,
    input  logic [XLEN-1:0]  rf_rdata,
    output logic             dump_valid,
    input  logic             dump_ready,
    output logic [RF_AW-1:0] dump_idx,
    output logic [XLEN-1:0]  dump_data,
    output logic             busy,
    output logic             done,
    output logic             ovf_err
);

    localparam logic [AW-1:0]    LAST_ADDR = AW'(IMEM_DEPTH - 1);
    localparam logic [RF_AW-1:0] LAST_IDX  = RF_AW'(NREGS - 1);

    state_e           state_q, state_d;
    logic [AW-1:0]    waddr_q, waddr_d;
    logic [RF_AW-1:0] idx_q, idx_d;
    logic             ovf_q, ovf_d;
    logic             tmr_load, tmr_dec, tmr_zero, tmr_one;

    // The run length is latched into the timer when start is accepted.
    core_dbg_timer #(.CYC_W(CYC_W)) u_timer (
        .clk_i  (CLK),
        .rst_i  (RST),
        .load_i (tmr_load),
        .val_i  (run_cycles),
        .dec_i  (tmr_dec),
        .zero_o (tmr_zero),
        .one_o  (tmr_one)
    );

    // Next-state and outputs; all outputs are decoded from the registered state.
    always_comb begin
        state_d    = state_q;
        waddr_d    = waddr_q;
        idx_d      = idx_q;
        ovf_d      = ovf_q;
        tmr_load   = 1'b0;
        tmr_dec    = 1'b0;
        load_ready = 1'b0;
        imem_we    = 1'b0;
        imem_wdata = '0;
        core_rst   = 1'b1;
        core_stall = 1'b0;
        dump_valid = 1'b0;
        dump_data  = '0;
        busy       = 1'b0;
        done       = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (state_q == ST_DONE) begin
                    // Keep the register file frozen so it can be re-read.
                    done       = 1'b1;
                    core_rst   = 1'b0;
                    core_stall = 1'b1;
                end
                if (start) begin
                    state_d  = ST_LOAD;
                    waddr_d  = '0;
                    idx_d    = '0;
                    ovf_d    = 1'b0;
                    tmr_load = 1'b1;
                end
            end
            ST_LOAD: begin
                busy       = 1'b1;
                load_ready = 1'b1;
                imem_we    = load_valid;
                imem_wdata = load_data;
                if (load_valid) begin
                    waddr_d = waddr_q + 1'b1;
                    // Last slot filled without a last marker truncates the program.
                    if (load_last || (waddr_q == LAST_ADDR)) begin
                        if (!load_last)
                            ovf_d = 1'b1;
                        state_d = tmr_zero ? ST_DUMP : ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                busy     = 1'b1;
                core_rst = 1'b0;
                tmr_dec  = 1'b1;
                if (tmr_one || tmr_zero)
                    state_d = ST_DUMP;
            end
            ST_DUMP: begin
                busy       = 1'b1;
                core_rst   = 1'b0;
                core_stall = 1'b1;
                dump_valid = 1'b1;
                dump_data  = rf_rdata;
                if (dump_ready) begin
                    if (idx_q == LAST_IDX)
                        state_d = ST_DONE;
                    else
                        idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            waddr_q <= '0;
            idx_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            waddr_q <= waddr_d;
            idx_q   <= idx_d;
            ovf_q   <= ovf_d;
        end
    end

    assign imem_waddr = waddr_q;
    assign rf_raddr   = idx_q;
    assign dump_idx   = idx_q;
    assign ovf_err    = ovf_q;

endmodule
